// File: rtl/bbc_sram_arbiter.sv
// bbc_sram_arbiter
//   Two-requester arbiter in front of a single SRAM-style host port.
//   Grants alternate on ties, there is one idle cycle between transfers, and a
//   small owner FIFO remembers which requester each accepted read belongs to so
//   that read data coming back in order can be routed to that requester.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   req{0,1}_sram_request__*     requester requests (valid/ack handshake)
//   req{0,1}_sram_response__*    ack, read data routed back to the owner
//   host_sram_request__*         granted request, all zero when not granted
//   host_sram_response__*        ack and read data from the shared host
//   protocol_error               sticky: read data arrived with no read pending
module bbc_sram_arbiter #(
  parameter int FIFO_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_sram_request__valid,
  input  logic        req0_sram_request__read_enable,
  input  logic        req0_sram_request__write_enable,
  input  logic [7:0]  req0_sram_request__select,
  input  logic [23:0] req0_sram_request__address,
  input  logic [63:0] req0_sram_request__write_data,
  input  logic        req1_sram_request__valid,
  input  logic        req1_sram_request__read_enable,
  input  logic        req1_sram_request__write_enable,
  input  logic [7:0]  req1_sram_request__select,
  input  logic [23:0] req1_sram_request__address,
  input  logic [63:0] req1_sram_request__write_data,
  output logic        req0_sram_response__ack,
  output logic        req0_sram_response__read_data_valid,
  output logic [63:0] req0_sram_response__read_data,
  output logic        req1_sram_response__ack,
  output logic        req1_sram_response__read_data_valid,
  output logic [63:0] req1_sram_response__read_data,
  output logic        host_sram_request__valid,
  output logic        host_sram_request__read_enable,
  output logic        host_sram_request__write_enable,
  output logic [7:0]  host_sram_request__select,
  output logic [23:0] host_sram_request__address,
  output logic [63:0] host_sram_request__write_data,
  input  logic        host_sram_response__ack,
  input  logic        host_sram_response__read_data_valid,
  input  logic [63:0] host_sram_response__read_data,
  output logic        protocol_error
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] FULL_CNT = (FIFO_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t               r_state;
  logic                 r_last_grant;
  logic [DEPTH-1:0]     r_owner;
  logic [FIFO_LOG2-1:0] r_wptr;
  logic [FIFO_LOG2-1:0] r_rptr;
  logic [FIFO_LOG2:0]   r_count;
  logic                 r_perr;

  logic w_full, w_elig0, w_elig1;
  logic w_g0, w_g1, w_ack0, w_ack1;
  logic w_push, w_push_id, w_has, w_pop, w_head;
  logic w_route0, w_route1;

  // Eligibility uses the registered count, so a pop this cycle only frees a
  // read slot from the next cycle on.
  assign w_full  = (r_count == FULL_CNT);
  assign w_elig0 = req0_sram_request__valid & (~req0_sram_request__read_enable | ~w_full);
  assign w_elig1 = req1_sram_request__valid & (~req1_sram_request__read_enable | ~w_full);

  // Qualifying with reset_n keeps every output low while reset is asserted.
  assign w_g0   = reset_n & (r_state == GRANT0);
  assign w_g1   = reset_n & (r_state == GRANT1);
  assign w_ack0 = w_g0 & req0_sram_request__valid & host_sram_response__ack;
  assign w_ack1 = w_g1 & req1_sram_request__valid & host_sram_response__ack;

  assign w_push    = (w_ack0 & req0_sram_request__read_enable) |
                     (w_ack1 & req1_sram_request__read_enable);
  assign w_push_id = w_ack1;
  assign w_has     = (r_count != '0);
  assign w_pop     = host_sram_response__read_data_valid & w_has;
  assign w_head    = r_owner[r_rptr];  // pre-push head, even on simultaneous push
  assign w_route0  = reset_n & w_pop & ~w_head;
  assign w_route1  = reset_n & w_pop &  w_head;

  always_comb begin
    host_sram_request__valid        = 1'b0;
    host_sram_request__read_enable  = 1'b0;
    host_sram_request__write_enable = 1'b0;
    host_sram_request__select       = '0;
    host_sram_request__address      = '0;
    host_sram_request__write_data   = '0;
    if (w_g0) begin
      host_sram_request__valid        = req0_sram_request__valid;
      host_sram_request__read_enable  = req0_sram_request__read_enable;
      host_sram_request__write_enable = req0_sram_request__write_enable;
      host_sram_request__select       = req0_sram_request__select;
      host_sram_request__address      = req0_sram_request__address;
      host_sram_request__write_data   = req0_sram_request__write_data;
    end else if (w_g1) begin
      host_sram_request__valid        = req1_sram_request__valid;
      host_sram_request__read_enable  = req1_sram_request__read_enable;
      host_sram_request__write_enable = req1_sram_request__write_enable;
      host_sram_request__select       = req1_sram_request__select;
      host_sram_request__address      = req1_sram_request__address;
      host_sram_request__write_data   = req1_sram_request__write_data;
    end
  end

  assign req0_sram_response__ack             = w_ack0;
  assign req1_sram_response__ack             = w_ack1;
  assign req0_sram_response__read_data_valid = w_route0;
  assign req1_sram_response__read_data_valid = w_route1;
  assign req0_sram_response__read_data       = w_route0 ? host_sram_response__read_data : '0;
  assign req1_sram_response__read_data       = w_route1 ? host_sram_response__read_data : '0;
  assign protocol_error                      = reset_n & r_perr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;  // requester 0 wins the first tie
      r_owner      <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_perr       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_elig0 && w_elig1) r_state <= r_last_grant ? GRANT0 : GRANT1;
          else if (w_elig0)       r_state <= GRANT0;
          else if (w_elig1)       r_state <= GRANT1;
        end
        GRANT0: begin
          // Abort (valid dropped) returns to IDLE without touching last_grant.
          if (!req0_sram_request__valid) r_state <= IDLE;
          else if (host_sram_response__ack) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b0;
          end
        end
        GRANT1: begin
          if (!req1_sram_request__valid) r_state <= IDLE;
          else if (host_sram_response__ack) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_push) begin
        r_owner[r_wptr] <= w_push_id;
        r_wptr          <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (host_sram_response__read_data_valid && !w_has) r_perr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bbc_sram_arbiter.sv
module tb_bbc_sram_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  logic        r0_v, r0_re, r0_we; logic [7:0] r0_sel; logic [23:0] r0_a; logic [63:0] r0_wd;
  logic        r1_v, r1_re, r1_we; logic [7:0] r1_sel; logic [23:0] r1_a; logic [63:0] r1_wd;
  logic        o_ack0, o_rdv0, o_ack1, o_rdv1;
  logic [63:0] o_rd0, o_rd1;
  logic        hv, hre, hwe; logic [7:0] hsel; logic [23:0] ha; logic [63:0] hwd;
  logic        h_ack, h_rdv; logic [63:0] h_rd;
  logic        perr;

  int checks = 0;
  int errors = 0;

  bbc_sram_arbiter #(.FIFO_LOG2(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_sram_request__valid(r0_v), .req0_sram_request__read_enable(r0_re),
    .req0_sram_request__write_enable(r0_we), .req0_sram_request__select(r0_sel),
    .req0_sram_request__address(r0_a), .req0_sram_request__write_data(r0_wd),
    .req1_sram_request__valid(r1_v), .req1_sram_request__read_enable(r1_re),
    .req1_sram_request__write_enable(r1_we), .req1_sram_request__select(r1_sel),
    .req1_sram_request__address(r1_a), .req1_sram_request__write_data(r1_wd),
    .req0_sram_response__ack(o_ack0), .req0_sram_response__read_data_valid(o_rdv0),
    .req0_sram_response__read_data(o_rd0),
    .req1_sram_response__ack(o_ack1), .req1_sram_response__read_data_valid(o_rdv1),
    .req1_sram_response__read_data(o_rd1),
    .host_sram_request__valid(hv), .host_sram_request__read_enable(hre),
    .host_sram_request__write_enable(hwe), .host_sram_request__select(hsel),
    .host_sram_request__address(ha), .host_sram_request__write_data(hwd),
    .host_sram_response__ack(h_ack), .host_sram_response__read_data_valid(h_rdv),
    .host_sram_response__read_data(h_rd),
    .protocol_error(perr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // gnt: which requester currently owns the host port (-1 none)
  int m_gnt = -1;
  int m_last = 1;
  bit m_perr = 0;
  int m_q[$];          // owners of outstanding reads, oldest first
  // observation logs for hand-written expectations
  int ack_log[$];
  int rd_who[$];
  logic [63:0] rd_dat[$];

  always @(negedge clk) begin
    logic [98:0] b0, b1, e_host, a_host;
    logic e_ack0, e_ack1, e_rdv0, e_rdv1, acc;
    logic [63:0] e_rd0, e_rd1;
    int sz;
    bit full, el0, el1;
    b0 = {r0_v, r0_re, r0_we, r0_sel, r0_a, r0_wd};
    b1 = {r1_v, r1_re, r1_we, r1_sel, r1_a, r1_wd};
    a_host = {hv, hre, hwe, hsel, ha, hwd};
    e_host = '0; e_ack0 = 0; e_ack1 = 0; e_rdv0 = 0; e_rdv1 = 0; e_rd0 = '0; e_rd1 = '0;
    if (reset_n) begin
      if (m_gnt == 0) e_host = b0;
      if (m_gnt == 1) e_host = b1;
      e_ack0 = (m_gnt == 0) && h_ack && r0_v;
      e_ack1 = (m_gnt == 1) && h_ack && r1_v;
      if (h_rdv && m_q.size() > 0) begin
        if (m_q[0] == 0) begin e_rdv0 = 1; e_rd0 = h_rd; end
        else             begin e_rdv1 = 1; e_rd1 = h_rd; end
      end
    end
    check("host_req", {29'd0, a_host}, {29'd0, e_host});
    check("ack0", {127'd0, o_ack0}, {127'd0, e_ack0});
    check("ack1", {127'd0, o_ack1}, {127'd0, e_ack1});
    check("rdv0", {127'd0, o_rdv0}, {127'd0, e_rdv0});
    check("rdv1", {127'd0, o_rdv1}, {127'd0, e_rdv1});
    check("rd0", {64'd0, o_rd0}, {64'd0, e_rd0});
    check("rd1", {64'd0, o_rd1}, {64'd0, e_rd1});
    check("perr", {127'd0, perr}, {127'd0, reset_n && m_perr});

    if (o_ack0) ack_log.push_back(0);
    if (o_ack1) ack_log.push_back(1);
    if (o_rdv0) begin rd_who.push_back(0); rd_dat.push_back(o_rd0); end
    if (o_rdv1) begin rd_who.push_back(1); rd_dat.push_back(o_rd1); end

    // next state, as seen at the upcoming rising edge
    if (!reset_n) begin
      m_gnt = -1; m_last = 1; m_perr = 0; m_q.delete();
    end else begin
      sz = m_q.size();
      full = (sz == 4);
      if (h_rdv) begin
        if (sz > 0) void'(m_q.pop_front());
        else m_perr = 1;
      end
      el0 = r0_v && (!r0_re || !full);
      el1 = r1_v && (!r1_re || !full);
      if (m_gnt == -1) begin
        if (el0 && el1) m_gnt = (m_last == 1) ? 0 : 1;
        else if (el0) m_gnt = 0;
        else if (el1) m_gnt = 1;
      end else begin
        acc = (m_gnt == 0) ? r0_v : r1_v;
        if (!acc) m_gnt = -1;
        else if (h_ack) begin
          if ((m_gnt == 0) ? r0_re : r1_re) m_q.push_back(m_gnt);
          m_last = m_gnt;
          m_gnt = -1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set0(input logic v, input logic re, input logic we, input logic [23:0] a, input logic [63:0] wd);
    r0_v = v; r0_re = re; r0_we = we; r0_sel = 8'hFF; r0_a = a; r0_wd = wd;
  endtask

  task automatic set1(input logic v, input logic re, input logic we, input logic [23:0] a, input logic [63:0] wd);
    r1_v = v; r1_re = re; r1_we = we; r1_sel = 8'h0F; r1_a = a; r1_wd = wd;
  endtask

  task automatic do_reset();
    reset_n = 0; tick(2); reset_n = 1;
    ack_log.delete(); rd_who.delete(); rd_dat.delete();
  endtask

  task automatic outputs_zero(input string name);
    check(name, {64'd0, hv, hre, hwe, hsel, ha, hwd[31:0], o_ack0, o_ack1, o_rdv0, o_rdv1, perr, o_rd0[0], o_rd1[0]}, '0);
  endtask

  initial begin
    reset_n = 0; h_ack = 0; h_rdv = 0; h_rd = '0;
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
    tick(1);
    outputs_zero("in_reset");
    do_reset();
    outputs_zero("after_reset");

    // single read from req0, ack one cycle after valid, data two cycles later
    set0(1, 1, 0, 24'h000100, 0);
    tick(1);
    check("t1_hv", {127'd0, hv}, 128'd1);
    check("t1_addr", {104'd0, ha}, 128'h100);
    tick(1); h_ack = 1;
    tick(1); h_ack = 0; set0(0, 0, 0, 0, 0);
    tick(2); h_rdv = 1; h_rd = 64'h0123456789ABCDEF;
    tick(1); h_rdv = 0; h_rd = '0;
    tick(1);
    check("t1_acks", {96'd0, 32'(ack_log.size())}, 128'd1);
    check("t1_rdcnt", {96'd0, 32'(rd_who.size())}, 128'd1);
    if (rd_who.size() == 1) begin
      check("t1_who", {96'd0, 32'(rd_who[0])}, 128'd0);
      check("t1_data", {64'd0, rd_dat[0]}, {64'd0, 64'h0123456789ABCDEF});
    end

    // both hold writes: alternating grants 0,1,0,1
    do_reset();
    set0(1, 0, 1, 24'h10, 64'hAAAA); set1(1, 0, 1, 24'h20, 64'hBBBB); h_ack = 1;
    tick(8);
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0); h_ack = 0;
    check("t2_acks", {96'd0, 32'(ack_log.size())}, 128'd4);
    if (ack_log.size() >= 4)
      check("t2_order", {124'd0, 1'(ack_log[0]), 1'(ack_log[1]), 1'(ack_log[2]), 1'(ack_log[3])}, 128'b0101);

    // fill owner FIFO with 4 req0 reads, req1 read blocked, write allowed
    do_reset();
    set0(1, 1, 0, 24'h30, 0); h_ack = 1;
    tick(10);
    set0(0, 0, 0, 0, 0);
    check("t3_fill", {96'd0, 32'(ack_log.size())}, 128'd4);
    set1(1, 1, 0, 24'h40, 0);
    tick(4);
    check("t3_blocked", {96'd0, 32'(ack_log.size())}, 128'd4);
    set1(1, 0, 1, 24'h41, 64'h55);
    tick(2);
    set1(0, 0, 0, 0, 0);
    check("t3_write", {96'd0, 32'(ack_log.size())}, 128'd5);
    h_rdv = 1; h_rd = 64'hD000;
    tick(1); h_rdv = 0;
    set1(1, 1, 0, 24'h42, 0);
    tick(2);
    set1(0, 0, 0, 0, 0); h_ack = 0;
    check("t3_read_after_pop", {96'd0, 32'(ack_log.size())}, 128'd6);
    for (int i = 1; i <= 4; i++) begin h_rdv = 1; h_rd = 64'hD000 + 64'(i); tick(1); end
    h_rdv = 0;
    check("t3_rdcnt", {96'd0, 32'(rd_who.size())}, 128'd5);
    if (rd_who.size() == 5)
      check("t3_route", {123'd0, 1'(rd_who[0]), 1'(rd_who[1]), 1'(rd_who[2]), 1'(rd_who[3]), 1'(rd_who[4])}, 128'b00001);

    // interleaved reads 0,1,0 with push and pop in the same cycle
    do_reset();
    set0(1, 1, 0, 24'h50, 0); h_ack = 1;
    tick(2);
    set0(0, 0, 0, 0, 0); set1(1, 1, 0, 24'h60, 0);
    tick(1);
    h_rdv = 1; h_rd = 64'h11;
    tick(1);
    set1(0, 0, 0, 0, 0); set0(1, 1, 0, 24'h70, 0); h_rdv = 0;
    tick(1);
    h_rdv = 1; h_rd = 64'h22;
    tick(1);
    set0(0, 0, 0, 0, 0); h_rd = 64'h33;
    tick(1);
    h_rdv = 0; h_ack = 0;
    check("t4_rdcnt", {96'd0, 32'(rd_who.size())}, 128'd3);
    if (rd_who.size() == 3) begin
      check("t4_route", {125'd0, 1'(rd_who[0]), 1'(rd_who[1]), 1'(rd_who[2])}, 128'b010);
      check("t4_data", {64'd0, rd_dat[0][7:0], rd_dat[1][7:0], rd_dat[2][7:0]}, 128'h112233);
    end
    check("t4_perr_clean", {127'd0, perr}, 128'd0);

    // stray read data: sticky protocol error, nothing routed
    h_rdv = 1; h_rd = 64'hBAD;
    tick(1); h_rdv = 0;
    check("t5_perr", {127'd0, perr}, 128'd1);
    tick(3);
    check("t5_perr_held", {127'd0, perr}, 128'd1);
    check("t5_norte", {96'd0, 32'(rd_who.size())}, 128'd3);
    reset_n = 0; tick(1);
    check("t5_perr_rst", {127'd0, perr}, 128'd0);
    reset_n = 1;
    tick(1);
    check("t5_perr_clr", {127'd0, perr}, 128'd0);

    // reset in GRANT1 with 2 reads outstanding
    do_reset();
    set0(1, 1, 0, 24'h80, 0); h_ack = 1;
    tick(4);
    set0(0, 0, 0, 0, 0); set1(1, 0, 1, 24'h90, 64'h99); h_ack = 0;
    tick(2);
    check("t6_outstanding", {96'd0, 32'(ack_log.size())}, 128'd2);
    check("t6_g1", {127'd0, hv}, 128'd1);
    reset_n = 0;
    tick(1);
    reset_n = 1;
    set0(1, 0, 1, 24'hA0, 64'h01); h_ack = 1;
    outputs_zero("t6_after_reset");
    tick(1);
    check("t6_tie_req0", {126'd0, o_ack0, o_ack1}, 128'b10);
    tick(1);
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0); h_ack = 0;
    tick(1);
    h_rdv = 1; h_rd = 64'h77;
    tick(1);
    check("t6_no_owner", {126'd0, o_rdv0, o_rdv1}, 128'd0);
    h_rdv = 0;
    tick(1);
    check("t6_perr", {127'd0, perr}, 128'd1);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
